// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller: branch flush, load-use bubble,
// sprite-access wait with timeout, and halt.
module hazard_stall_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_src_s,
    input  logic [4:0] ID_src_t,
    input  logic       ID_uses_s,
    input  logic       ID_uses_t,
    input  logic [4:0] EX_dst_reg,
    input  logic       EX_use_dst_reg,
    input  logic       EX_mem_re,
    input  logic       EX_branch_taken,
    input  logic       ID_sprite_re,
    input  logic       ID_sprite_we,
    input  logic       sprite_ready,
    input  logic       ID_hlt,
    output logic       pc_hold,
    output logic       stall_IF_ID,
    output logic       flush_IF_ID,
    output logic       flush_ID_EX,
    output logic       sprite_req,
    output logic       hlt,
    output logic       sprite_timeout,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StRun        = 2'd0,
        StSpriteWait = 2'd1,
        StHalt       = 2'd2
    } state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_next;
    logic       r_sprite_done;
    logic       w_sprite_done_next;
    logic       r_sprite_req;
    logic       w_sprite_req_next;
    logic       r_sprite_timeout;
    logic       w_sprite_timeout_next;

    logic       w_load_use;
    logic       w_sprite_access;
    logic       w_pc_hold;
    logic       w_stall_if_id;
    logic       w_flush_if_id;
    logic       w_flush_id_ex;
    logic       w_hlt;

    assign w_load_use = EX_mem_re & EX_use_dst_reg & (EX_dst_reg != 5'd0) &
                        ((ID_uses_s & (ID_src_s == EX_dst_reg)) |
                         (ID_uses_t & (ID_src_t == EX_dst_reg)));

    assign w_sprite_access = ID_sprite_re | ID_sprite_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= StRun;
            r_wait_cnt       <= 8'd0;
            r_sprite_done    <= 1'b0;
            r_sprite_req     <= 1'b0;
            r_sprite_timeout <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_wait_cnt       <= w_wait_cnt_next;
            r_sprite_done    <= w_sprite_done_next;
            r_sprite_req     <= w_sprite_req_next;
            r_sprite_timeout <= w_sprite_timeout_next;
        end
    end

    always_comb begin
        w_state_next          = r_state;
        w_wait_cnt_next       = r_wait_cnt;
        w_sprite_done_next    = 1'b0;
        w_sprite_req_next     = 1'b0;
        w_sprite_timeout_next = r_sprite_timeout;
        w_pc_hold             = 1'b0;
        w_stall_if_id         = 1'b0;
        w_flush_if_id         = 1'b0;
        w_flush_id_ex         = 1'b0;
        w_hlt                 = 1'b0;

        case (r_state)
            StRun: begin
                if (EX_branch_taken) begin
                    w_flush_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                end else if (w_load_use) begin
                    w_pc_hold     = 1'b1;
                    w_stall_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                end else if (w_sprite_access && !r_sprite_done) begin
                    // sprite_done keeps the just-serviced access from retriggering
                    w_state_next      = StSpriteWait;
                    w_wait_cnt_next   = 8'd0;
                    w_sprite_req_next = 1'b1;
                end else if (ID_hlt) begin
                    w_state_next = StHalt;
                end
            end
            StSpriteWait: begin
                if (sprite_ready) begin
                    w_state_next       = StRun;
                    w_sprite_done_next = 1'b1;
                end else begin
                    w_pc_hold     = 1'b1;
                    w_stall_if_id = 1'b1;
                    w_flush_id_ex = 1'b1;
                    if (r_wait_cnt == 8'd255) begin
                        w_sprite_timeout_next = 1'b1;
                        w_state_next          = StRun;
                        w_sprite_done_next    = 1'b1;
                    end else begin
                        w_wait_cnt_next = r_wait_cnt + 8'd1;
                    end
                end
            end
            StHalt: begin
                w_hlt         = 1'b1;
                w_pc_hold     = 1'b1;
                w_stall_if_id = 1'b1;
                w_flush_id_ex = 1'b1;
            end
            default: begin
                w_state_next = StRun;
            end
        endcase
    end

    // Outputs are forced low for the whole reset window, not just after the edge.
    assign pc_hold        = w_pc_hold & ~rst;
    assign stall_IF_ID    = w_stall_if_id & ~rst;
    assign flush_IF_ID    = w_flush_if_id & ~rst;
    assign flush_ID_EX    = w_flush_id_ex & ~rst;
    assign hlt            = w_hlt & ~rst;
    assign sprite_req     = r_sprite_req & ~rst;
    assign sprite_timeout = r_sprite_timeout & ~rst;
    assign state          = rst ? 2'd0 : r_state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized and directed bench for hazard_stall_ctrl against a behavioural model.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_src_s, ID_src_t, EX_dst_reg;
    logic       ID_uses_s, ID_uses_t, EX_use_dst_reg, EX_mem_re, EX_branch_taken;
    logic       ID_sprite_re, ID_sprite_we, sprite_ready, ID_hlt;
    logic       pc_hold, stall_IF_ID, flush_IF_ID, flush_ID_EX;
    logic       sprite_req, hlt, sprite_timeout;
    logic [1:0] state;

    hazard_stall_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .ID_src_s       (ID_src_s),
        .ID_src_t       (ID_src_t),
        .ID_uses_s      (ID_uses_s),
        .ID_uses_t      (ID_uses_t),
        .EX_dst_reg     (EX_dst_reg),
        .EX_use_dst_reg (EX_use_dst_reg),
        .EX_mem_re      (EX_mem_re),
        .EX_branch_taken(EX_branch_taken),
        .ID_sprite_re   (ID_sprite_re),
        .ID_sprite_we   (ID_sprite_we),
        .sprite_ready   (sprite_ready),
        .ID_hlt         (ID_hlt),
        .pc_hold        (pc_hold),
        .stall_IF_ID    (stall_IF_ID),
        .flush_IF_ID    (flush_IF_ID),
        .flush_ID_EX    (flush_ID_EX),
        .sprite_req     (sprite_req),
        .hlt            (hlt),
        .sprite_timeout (sprite_timeout),
        .state          (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int req_seen = 0;
    int stall_seen = 0;

    // Model: mode 0=running, 1=waiting on sprite, 2=halted
    int m_mode = 0;
    int m_waited = 0;
    bit m_done = 0;
    bit m_req = 0;
    bit m_to = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_lu();
        int d = EX_dst_reg;
        return EX_mem_re && EX_use_dst_reg && d != 0 &&
               ((ID_uses_s && int'(ID_src_s) == d) || (ID_uses_t && int'(ID_src_t) == d));
    endfunction

    function automatic logic [31:0] dut_vec();
        return {23'd0, pc_hold, stall_IF_ID, flush_IF_ID, flush_ID_EX,
                sprite_req, hlt, sprite_timeout, state};
    endfunction

    function automatic logic [31:0] model_out();
        bit hold = 0, stl = 0, fif = 0, fex = 0, h = 0;
        if (rst) return 32'd0;
        if (m_mode == 0) begin
            if (EX_branch_taken) begin
                fif = 1; fex = 1;
            end else if (model_lu()) begin
                hold = 1; stl = 1; fex = 1;
            end
        end else if (m_mode == 1) begin
            if (!sprite_ready) begin
                hold = 1; stl = 1; fex = 1;
            end
        end else begin
            h = 1; hold = 1; stl = 1; fex = 1;
        end
        return {23'd0, hold, stl, fif, fex, m_req, h, m_to, 2'(m_mode)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_done = 0; m_req = 0; m_to = 0;
    endtask

    task automatic model_update();
        bit access = ID_sprite_re || ID_sprite_we;
        bit was_done = m_done;
        if (rst) begin
            model_reset();
            return;
        end
        m_done = 0;
        m_req = 0;
        if (m_mode == 0) begin
            if (!EX_branch_taken && !model_lu()) begin
                if (access && !was_done) begin
                    m_mode = 1; m_waited = 0; m_req = 1;
                end else if (ID_hlt) begin
                    m_mode = 2;
                end
            end
        end else if (m_mode == 1) begin
            if (sprite_ready) begin
                m_mode = 0; m_done = 1;
            end else if (m_waited == 255) begin
                m_to = 1; m_mode = 0; m_done = 1;
            end else begin
                m_waited++;
            end
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_eq(tag, dut_vec(), model_out());
        if (sprite_req) req_seen++;
        if (stall_IF_ID) stall_seen++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        ID_src_s = 0; ID_src_t = 0; ID_uses_s = 0; ID_uses_t = 0;
        EX_dst_reg = 0; EX_use_dst_reg = 0; EX_mem_re = 0; EX_branch_taken = 0;
        ID_sprite_re = 0; ID_sprite_we = 0; sprite_ready = 0; ID_hlt = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step("reset");
        rst = 0;
    endtask

    task automatic rand_inputs();
        ID_src_s        = 5'($urandom_range(0, 3));
        ID_src_t        = 5'($urandom_range(0, 3));
        EX_dst_reg      = 5'($urandom_range(0, 3));
        ID_uses_s       = 1'($urandom_range(0, 1));
        ID_uses_t       = 1'($urandom_range(0, 1));
        EX_use_dst_reg  = 1'($urandom_range(0, 1));
        EX_mem_re       = 1'($urandom_range(0, 1));
        EX_branch_taken = ($urandom_range(0, 7) == 0);
        ID_sprite_re    = ($urandom_range(0, 5) == 0);
        ID_sprite_we    = ($urandom_range(0, 5) == 0);
        sprite_ready    = ($urandom_range(0, 2) == 0);
        ID_hlt          = ($urandom_range(0, 59) == 0);
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        EX_branch_taken = 1;
        ID_hlt = 1;
        #1;
        step("reset_gated");
        clear_inputs();
        do_reset();

        // Load-use bubble, then the same with r0 destination
        EX_mem_re = 1; EX_use_dst_reg = 1; EX_dst_reg = 5; ID_uses_s = 1; ID_src_s = 5;
        step("lu_stall");
        EX_dst_reg = 0; ID_src_s = 0;
        step("lu_r0");
        clear_inputs();

        // Branch outranks every other condition
        EX_branch_taken = 1; EX_mem_re = 1; EX_use_dst_reg = 1; EX_dst_reg = 7;
        ID_uses_t = 1; ID_src_t = 7; ID_sprite_we = 1; ID_hlt = 1;
        step("branch_over");
        check_eq("branch_state", state, 0);
        clear_inputs();

        // Sprite handshake with ready after four wait cycles
        req_seen = 0; stall_seen = 0;
        ID_sprite_re = 1;
        step("spr_trig");
        for (int i = 0; i < 4; i++) step("spr_wait");
        sprite_ready = 1;
        step("spr_ready");
        sprite_ready = 0;
        step("spr_noretrig");
        check_eq("spr_req_pulses", req_seen, 1);
        check_eq("spr_stall_cycles", stall_seen, 4);
        check_eq("spr_state_back", state, 0);
        clear_inputs();

        // Timeout with ready never arriving
        do_reset();
        ID_sprite_we = 1;
        step("to_trig");
        for (int i = 0; i < 256; i++) step("to_wait");
        check_eq("to_flag", sprite_timeout, 1);
        check_eq("to_state", state, 0);
        ID_sprite_we = 0;
        step("to_sticky");
        check_eq("to_sticky_flag", sprite_timeout, 1);

        // Ready on the final wait cycle beats the timeout
        do_reset();
        ID_sprite_we = 1;
        step("edge_trig");
        for (int i = 0; i < 255; i++) step("edge_wait");
        sprite_ready = 1;
        step("edge_ready");
        check_eq("edge_no_to", sprite_timeout, 0);
        check_eq("edge_state", state, 0);
        clear_inputs();

        // Halt persists, then asynchronous reset clears it mid-cycle
        ID_hlt = 1;
        step("hlt_trig");
        ID_hlt = 0;
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            step("hlt_hold");
        end
        check_eq("hlt_state", state, 2);
        @(negedge clk);
        rst = 1;
        #1;
        model_reset();
        check_eq("rst_async_out", dut_vec(), 0);
        rst = 0;
        #1;
        check_eq("rst_async_state", dut_vec(), model_out());
        @(posedge clk);
        model_update();
        #1;
        clear_inputs();
        step("post_rst");

        // Randomized traffic, periodically reset to escape halt
        for (int blk = 0; blk < 8; blk++) begin
            do_reset();
            for (int i = 0; i < 250; i++) begin
                rand_inputs();
                step("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
